// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, with a start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    cnt;
    logic             bi;

    logic x;
    logic y;
    logic d;
    logic bo;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
`endif

    assign x  = a_sr[0];
    assign y  = b_sr[0];
    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

    // The minuend register doubles as the result register: each difference bit
    // enters at the MSB as the consumed operand bit leaves at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            cnt    <= '0;
            bi     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        cnt   <= '0;
                        bi    <= 1'b0;
                        busy  <= 1'b1;
                        state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr <= {d, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    bi   <= bo;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        diff   <= {d, a_sr[WIDTH-1:1]};
                        borrow <= bo;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        ovf    <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic reference model.
// Define SERIAL_SUB_OVF_EN to also check the ovf output.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the operand values.
    function automatic logic [W-1:0] refDiff(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = int'(x) - int'(y);
        r = ((r % (1 << W)) + (1 << W)) % (1 << W);
        return W'(r);
    endfunction

    function automatic logic refBorrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return int'(x) < int'(y);
    endfunction

    function automatic logic refOvf(input logic [W-1:0] x, input logic [W-1:0] y);
        int s;
        s = int'($signed(x)) - int'($signed(y));
        return (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResult(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        checkOutput({tag, " diff"}, 32'(diff), 32'(refDiff(x, y)));
        checkOutput({tag, " borrow"}, 32'(borrow), 32'(refBorrow(x, y)));
`ifdef SERIAL_SUB_OVF_EN
        checkOutput({tag, " ovf"}, 32'(ovf), 32'(refOvf(x, y)));
`endif
    endtask

    // Launch one operation, scramble the inputs while it runs, and check timing and result.
    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        int lat;
        int busyCycles;
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busyCycles = busy ? 1 : 0;
        while (!done && lat < 40) begin
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            lat++;
            if (busy) busyCycles++;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(W));
        checkOutput({tag, " busy cycles"}, 32'(busyCycles), 32'(W));
        checkResult(tag, x, y);
        @(negedge clk);
        checkOutput({tag, " done pulse width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int bad;
        logic [W-1:0] rx;
        logic [W-1:0] ry;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset diff", 32'(diff), 32'd0);
        checkOutput("reset borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        checkOutput("reset ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;

        applyStimulus(8'h5A, 8'h3C, "5A-3C");
        applyStimulus(8'h00, 8'h01, "00-01");
        applyStimulus(8'h80, 8'h01, "80-01");
        applyStimulus(8'h7F, 8'hFF, "7F-FF");
        applyStimulus(8'hA5, 8'h00, "b zero");
        applyStimulus(8'hC3, 8'hC3, "a eq b");

        for (int i = 0; i < 16; i++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            applyStimulus(rx, ry, "random");
        end

        // A start pulse mid-operation must be ignored and not queued.
        @(negedge clk);
        a = 8'h10;
        b = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 3) begin
                start = 1'b1;
                a = 8'hFF;
                b = 8'h00;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput("ignore latency", 32'(lat), 32'(W));
        checkResult("ignore", 8'h10, 8'h01);
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy || done) bad++;
        end
        checkOutput("ignore no queued op", 32'(bad), 32'd0);

        // Reset mid-operation discards everything.
        @(negedge clk);
        a = 8'h33;
        b = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort diff", 32'(diff), 32'd0);
        checkOutput("abort borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        checkOutput("abort ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy || done) bad++;
        end
        checkOutput("abort no done", 32'(bad), 32'd0);

        // Back-to-back with start held and operands switched in the DONE cycle.
        @(negedge clk);
        a = 8'h09;
        b = 8'h0A;
        start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 40);
        checkOutput("b2b first latency", 32'(lat), 32'(W + 1));
        checkResult("b2b first", 8'h09, 8'h0A);
        a = 8'h0A;
        b = 8'h09;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        checkOutput("b2b accept busy", 32'(busy), 32'd1);
        checkOutput("b2b done drops", 32'(done), 32'd0);
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("b2b spacing", 32'(lat), 32'(W + 1));
        checkResult("b2b second", 8'h0A, 8'h09);

        // Idle hold: outputs stay put while the operand inputs wander.
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            a = W'($urandom);
            b = W'($urandom);
            if (busy || done || diff !== refDiff(8'h0A, 8'h09) || borrow !== refBorrow(8'h0A, 8'h09))
                bad++;
        end
        checkOutput("idle hold", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
